// File: rtl/l2_arbiter_pkg.sv
//------------------------------------------------------------------------------
// l2_arbiter_pkg : shared types and defaults for the L1/L2 arbitration block
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package l2_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } req_side_t;

  // Round-robin tie-break: the side that was not served last wins.
  function automatic req_side_t rr_pick(input req_side_t last);
    return (last == SIDE_I) ? SIDE_D : SIDE_I;
  endfunction

endpackage

`default_nettype wire

// File: rtl/l2_arbiter.sv
//------------------------------------------------------------------------------
// l2_arbiter : round-robin arbiter sharing one L2 port between L1 I and D misses
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic              busy
);

  arb_state_t state, state_n;
  req_side_t  last_grant, last_grant_n;
  logic       i_req, d_req;

  assign i_req = i_read;
  // Both D strobes high is illegal and counts as no request.
  assign d_req = d_read ^ d_write;

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          last_grant_n = rr_pick(last_grant);
          state_n      = (rr_pick(last_grant) == SIDE_I) ? SERVE_I : SERVE_D;
        end else if (i_req) begin
          last_grant_n = SIDE_I;
          state_n      = SERVE_I;
        end else if (d_req) begin
          last_grant_n = SIDE_D;
          state_n      = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SIDE_I;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
    end
  end

  // L2 request lines are a pure mux of the granted side; IDLE forces them low,
  // which gives the L2 controller its mandatory bubble between transactions.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = '0;
    l2_wdata = '0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    case (state)
      SERVE_I: begin
        l2_read = i_read;
        l2_addr = i_addr;
        i_resp  = l2_resp;
      end
      SERVE_D: begin
        l2_read  = d_read;
        l2_write = d_write;
        l2_addr  = d_addr;
        l2_wdata = d_wdata;
        d_resp   = l2_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;
  assign busy    = (state != IDLE);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(d_read && d_write))
        else $warning("l2_arbiter: d_read and d_write both high");
      assert (!(state == IDLE && l2_resp))
        else $warning("l2_arbiter: l2_resp seen while idle");
      assert (!(state == SERVE_I && !i_read) && !(state == SERVE_D && !d_req))
        else $warning("l2_arbiter: granted requester dropped its request");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_arbiter.sv
//------------------------------------------------------------------------------
// tb_l2_arbiter : directed self-checking bench for l2_arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_l2_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read, d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              l2_read, l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;
  logic              busy;

  int total = 0;
  int bad   = 0;

  localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_5A = {32{8'h5A}};
  localparam logic [LINE_W-1:0] PAT_3C = {32{8'h3C}};

  always #5 clk = ~clk;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_read   (i_read),
    .i_addr   (i_addr),
    .i_resp   (i_resp),
    .i_rdata  (i_rdata),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_resp   (d_resp),
    .d_rdata  (d_rdata),
    .l2_read  (l2_read),
    .l2_write (l2_write),
    .l2_addr  (l2_addr),
    .l2_wdata (l2_wdata),
    .l2_rdata (l2_rdata),
    .l2_resp  (l2_resp),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks follow a 1-unit settle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_l2_read"},  l2_read,  '0);
    chk({tag, "_l2_write"}, l2_write, '0);
    chk({tag, "_busy"},     busy,     '0);
  endtask

  initial begin
    rst = 1'b1; i_read = 0; i_addr = '0; d_read = 0; d_write = 0;
    d_addr = '0; d_wdata = '0; l2_rdata = '0; l2_resp = 0;

    // Reset state
    tick(); tick(); settle();
    idle_checks("rst");
    chk("rst_l2_addr",  l2_addr,  '0);
    chk("rst_l2_wdata", l2_wdata, '0);
    chk("rst_i_resp",   i_resp,   '0);
    chk("rst_d_resp",   d_resp,   '0);
    rst = 1'b0;

    // Single I read with 3-cycle L2 latency
    tick();
    i_read = 1; i_addr = 32'h0000_1000;
    tick(); settle();
    chk("t1_grant_read", l2_read, 1'b1);
    chk("t1_grant_write", l2_write, 1'b0);
    chk("t1_grant_addr", l2_addr, 32'h1000);
    chk("t1_busy", busy, 1'b1);
    tick(); tick();
    l2_resp = 1; l2_rdata = PAT_A5; settle();
    chk("t1_i_resp", i_resp, 1'b1);
    chk("t1_i_rdata", i_rdata, PAT_A5);
    chk("t1_d_resp", d_resp, 1'b0);
    tick();
    l2_resp = 0; i_read = 0; settle();
    idle_checks("t1_after");
    chk("t1_i_resp_once", i_resp, 1'b0);

    // Simultaneous I read / D write straight after reset: D wins
    rst = 1; tick(); rst = 0;
    i_read = 1; i_addr = 32'h2000;
    d_write = 1; d_addr = 32'h3000; d_wdata = PAT_5A;
    tick(); settle();
    chk("t2_d_write", l2_write, 1'b1);
    chk("t2_d_read",  l2_read,  1'b0);
    chk("t2_d_addr",  l2_addr,  32'h3000);
    chk("t2_d_wdata", l2_wdata, PAT_5A);
    l2_resp = 1; settle();
    chk("t2_d_resp", d_resp, 1'b1);
    chk("t2_i_noresp", i_resp, 1'b0);
    tick();
    l2_resp = 0; d_write = 0; d_wdata = '0; settle();
    idle_checks("t2_bubble");
    tick(); settle();
    chk("t2_i_read", l2_read, 1'b1);
    chk("t2_i_addr", l2_addr, 32'h2000);
    chk("t2_i_wdata", l2_wdata, '0);
    l2_resp = 1; l2_rdata = PAT_3C; settle();
    chk("t2_i_resp", i_resp, 1'b1);
    chk("t2_i_rdata", i_rdata, PAT_3C);
    tick();
    l2_resp = 0; i_read = 0;

    // Three D reads while I holds a read: D, I, D, D (last_grant is I here)
    i_read = 1; i_addr = 32'h0000_6000;
    d_read = 1; d_addr = 32'h0000_4000;
    tick(); settle();
    chk("t3_g1_addr", l2_addr, 32'h4000);
    chk("t3_g1_read", l2_read, 1'b1);
    l2_resp = 1; settle();
    chk("t3_g1_d_resp", d_resp, 1'b1);
    tick();
    l2_resp = 0; d_addr = 32'h0000_4040; settle();
    idle_checks("t3_b1");
    tick(); settle();
    chk("t3_g2_addr", l2_addr, 32'h6000);
    chk("t3_g2_busy", busy, 1'b1);
    l2_resp = 1; settle();
    chk("t3_g2_i_resp", i_resp, 1'b1);
    chk("t3_g2_d_noresp", d_resp, 1'b0);
    tick();
    l2_resp = 0; i_read = 0; settle();
    idle_checks("t3_b2");
    tick(); settle();
    chk("t3_g3_addr", l2_addr, 32'h4040);
    l2_resp = 1; settle();
    chk("t3_g3_d_resp", d_resp, 1'b1);
    tick();
    l2_resp = 0; d_addr = 32'h0000_4080; settle();
    idle_checks("t3_b3");
    tick(); settle();
    chk("t3_g4_addr", l2_addr, 32'h4080);
    chk("t3_g4_read", l2_read, 1'b1);
    l2_resp = 1; settle();
    chk("t3_g4_d_resp", d_resp, 1'b1);
    tick();
    l2_resp = 0; d_read = 0; settle();
    idle_checks("t3_end");

    // Reset two cycles into SERVE_D, then a held I request is granted
    d_read = 1; d_addr = 32'h0000_5000;
    tick(); settle();
    chk("t4_serve_d", l2_addr, 32'h5000);
    tick();
    rst = 1; i_read = 1; i_addr = 32'h0000_7000;
    tick(); settle();
    idle_checks("t4_rst");
    chk("t4_d_resp", d_resp, 1'b0);
    chk("t4_l2_addr", l2_addr, '0);
    rst = 0; d_read = 0;
    tick(); settle();
    chk("t4_i_grant", l2_read, 1'b1);
    chk("t4_i_addr", l2_addr, 32'h7000);
    l2_resp = 1; settle();
    chk("t4_i_resp", i_resp, 1'b1);
    tick();
    l2_resp = 0; i_read = 0;

    // Illegal d_read and d_write together: no grant
    d_read = 1; d_write = 1; d_addr = 32'h0000_8000;
    tick(); settle();
    idle_checks("t5_c1");
    tick(); settle();
    idle_checks("t5_c2");
    d_read = 0; d_write = 0;

    // Stray l2_resp in IDLE: ignored
    tick();
    l2_resp = 1; settle();
    chk("t6_i_resp", i_resp, 1'b0);
    chk("t6_d_resp", d_resp, 1'b0);
    tick();
    l2_resp = 0; settle();
    idle_checks("t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
